hit_bitmap_store: RTL and testbench
===================================

HIT_BITMAP_STORE -- requirements
Module: hit_bitmap_store

Interface
REQ-001 SHALL have parameter ROWBITS, default 4: row index width; MEMNROWS = 2^ROWBITS.
REQ-002 SHALL have parameter COLBITS, default 3: column index width; WORDLENGTH = 2^COLBITS bitmap bits per row.
REQ-003 SHALL have parameter COUNTBITS, default 4: per-row saturating hit counter width.
REQ-004 SHALL have port clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port resetN  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port hitValid  in  1  hitAddress carries a new hit.
REQ-007 SHALL have port hitAddress  in  ROWBITS+COLBITS  upper ROWBITS bits = row, lower COLBITS bits = column.
REQ-008 SHALL have port hitReady  out  1  hit accepted on a cycle where hitValid && hitReady.
REQ-009 SHALL have port clearStart  in  1  single-cycle request to zero all rows.
REQ-010 SHALL have port readStart  in  1  single-cycle request to stream out non-empty rows.
REQ-011 SHALL have port outValid  out  1  readout beat present.
REQ-012 SHALL have port outReady  in  1  consumer accepts beat when outValid && outReady.
REQ-013 SHALL have port outRow  out  ROWBITS  row index of beat.
REQ-014 SHALL have port outBitmap  out  WORDLENGTH  OR of hit column one-hots for row.
REQ-015 SHALL have port outCount  out  COUNTBITS  accepted hits in row, duplicates included, saturating.
REQ-016 SHALL have port readDone  out  1  one-cycle pulse after last readout beat accepted.
REQ-017 SHALL have port busy  out  1  high in CLEAR, DRAIN or READOUT.

Function
REQ-018 SHALL store per row {bitmap, count} in a dual-port RAM with 1-cycle read latency.
REQ-019 SHALL use states IDLE, DRAIN, CLEAR, READOUT; hitReady high only in IDLE.
REQ-020 SHALL update a hit by read-modify-write: read row at cycle N, write bitmap|(1<<col) and count+1 (saturate at 2^COUNTBITS-1) at cycle N+1.
REQ-021 SHALL forward pending write data when consecutive hits target the same row, merging with no lost bit or count at one hit per cycle.
REQ-022 SHALL on clearStart or readStart in IDLE enter DRAIN, hitReady low, until the write pipeline is empty (max 2 cycles), then enter CLEAR or READOUT.
REQ-023 SHALL give clearStart priority when clearStart and readStart coincide; readStart is dropped.
REQ-024 SHALL in CLEAR zero two rows per cycle on both ports, MEMNROWS/2 cycles, then return to IDLE.
REQ-025 SHALL in READOUT scan rows 0..MEMNROWS-1 ascending and emit only rows with nonzero bitmap.
REQ-026 SHALL hold outRow/outBitmap/outCount stable while outValid && !outReady; a 2-entry skid buffer absorbs RAM latency with no lost or duplicated beats.
REQ-027 SHALL pulse readDone one cycle after the final beat is accepted, or after the scan completes with zero beats, then return to IDLE.
REQ-028 SHALL treat clearStart during READOUT as abort: outValid low next cycle, skid buffer flushed, no readDone, enter CLEAR.
REQ-029 SHALL ignore readStart outside IDLE, and clearStart during DRAIN or CLEAR.
REQ-030 SHALL leave memory contents unchanged by readout.

Reset
REQ-031 SHALL on resetN low asynchronously force hitReady=0, outValid=0, readDone=0, busy=1, pipeline and skid buffer empty.
REQ-032 SHALL after resetN rises run a full CLEAR (MEMNROWS/2 cycles), then enter IDLE with hitReady=1, busy=0.
REQ-033 SHALL treat reset mid-operation identically; partial writes, clears or readouts are discarded.

Verification (ROWBITS=4, COLBITS=3, COUNTBITS=4)
REQ-034 SHALL cover: reset release -> busy high 8 cycles, hitReady then 1; readStart -> no beats, readDone pulse.
REQ-035 SHALL cover: hits 0x13, 0x15, 0x13 on consecutive cycles, readStart -> single beat row=2, bitmap=0x28, count=3.
REQ-036 SHALL cover: 20 consecutive hits 0x08 -> beat row=1, bitmap=0x01, count=15.
REQ-037 SHALL cover: hits in rows 0, 5, 15, outReady low 10 cycles per beat -> beats in order 0, 5, 15, stable while stalled, one readDone.
REQ-038 SHALL cover: clearStart one cycle after first beat accepted -> outValid 0 next cycle, no readDone, busy 8 cycles, later readout empty.
REQ-039 SHALL cover: clearStart and readStart same cycle in IDLE with data present -> clear only, no beats, no readDone.

Source files
------------

// File: rtl/hit_bitmap_store.sv
// hit_bitmap_store: per-row hit bitmap/count RAM; hitValid/hitAddress/hitReady feed an RMW hit path, clearStart zeroes all rows, readStart streams non-empty rows on outValid/outReady/outRow/outBitmap/outCount, readDone ends a readout, busy flags CLEAR/DRAIN/READOUT
module hit_bitmap_store #(
  parameter int ROWBITS = 4,
  parameter int COLBITS = 3,
  parameter int COUNTBITS = 4
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       hitValid,
  input  logic [ROWBITS+COLBITS-1:0] hitAddress,
  output logic                       hitReady,
  input  logic                       clearStart,
  input  logic                       readStart,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [ROWBITS-1:0]         outRow,
  output logic [(1<<COLBITS)-1:0]    outBitmap,
  output logic [COUNTBITS-1:0]       outCount,
  output logic                       readDone,
  output logic                       busy
);
  localparam int MEMNROWS = 1 << ROWBITS;
  localparam int WORDLENGTH = 1 << COLBITS;
  localparam int DW = WORDLENGTH + COUNTBITS;
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, READOUT} state_t;
  state_t state_q, state_d;
  logic tgt_clr_q, tgt_clr_d;
  logic [DW-1:0] mem [MEMNROWS];
  logic [DW-1:0] rd_q, old, new_data, wb_data_q;
  logic [COUNTBITS-1:0] old_ct;
  logic s1_valid_q, wb_valid_q, rv_q, rp_q, wp_q;
  logic [ROWBITS-1:0] s1_row_q, wb_row_q, rrow_q, ra, hit_row;
  logic [COLBITS-1:0] s1_col_q;
  logic [ROWBITS-2:0] clr_q;
  logic [ROWBITS:0] scan_q;
  logic [1:0] cnt_q;
  logic [WORDLENGTH-1:0] fb_q [2];
  logic [ROWBITS-1:0] fr_q [2];
  logic [COUNTBITS-1:0] fc_q [2];
  logic hit_acc, in_clr, in_rd, issue, push, pop, finished;
  assign hit_row = hitAddress[ROWBITS+COLBITS-1:COLBITS];
  assign in_clr = state_q == CLEAR;
  assign in_rd = state_q == READOUT;
  assign hitReady = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign hit_acc = hitValid && hitReady;
  // the write issued last cycle is not yet visible in rd_q, so a same-row hit takes it instead
  assign old = (wb_valid_q && wb_row_q == s1_row_q) ? wb_data_q : rd_q;
  assign old_ct = old[COUNTBITS-1:0];
  assign new_data = {old[DW-1:COUNTBITS] | (WORDLENGTH'(1) << s1_col_q), &old_ct ? old_ct : old_ct + COUNTBITS'(1)};
  assign ra = in_rd ? scan_q[ROWBITS-1:0] : hit_row;
  // a read is only launched if the skid buffer can take it even when nothing drains
  assign issue = in_rd && !clearStart && !scan_q[ROWBITS] && ({1'b0, cnt_q} + {2'b0, rv_q}) < 3'd2;
  assign push = rv_q && |rd_q[DW-1:COUNTBITS];
  assign outValid = in_rd && cnt_q != 2'd0;
  assign pop = outValid && outReady;
  assign finished = in_rd && scan_q[ROWBITS] && !rv_q && cnt_q == 2'd0;
  assign readDone = finished && !clearStart;
  assign outRow = fr_q[rp_q];
  assign outBitmap = fb_q[rp_q];
  assign outCount = fc_q[rp_q];
  always_comb begin
    state_d = state_q;
    tgt_clr_d = tgt_clr_q;
    case (state_q)
      IDLE: if (clearStart || readStart) begin
        state_d = DRAIN;
        tgt_clr_d = clearStart;
      end
      DRAIN: if (!s1_valid_q) state_d = tgt_clr_q ? CLEAR : READOUT;
      CLEAR: if (&clr_q) state_d = IDLE;
      READOUT: state_d = clearStart ? CLEAR : finished ? IDLE : READOUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (in_clr) mem[{clr_q, 1'b0}] <= '0;
    if (in_clr || s1_valid_q) mem[in_clr ? {clr_q, 1'b1} : s1_row_q] <= in_clr ? '0 : new_data;
    rd_q <= mem[ra];
  end
  always_ff @(posedge clock) begin
    if (push) begin
      fb_q[wp_q] <= rd_q[DW-1:COUNTBITS];
      fr_q[wp_q] <= rrow_q;
      fc_q[wp_q] <= rd_q[COUNTBITS-1:0];
    end
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= CLEAR;
      tgt_clr_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_row_q <= '0;
      s1_col_q <= '0;
      wb_valid_q <= 1'b0;
      wb_row_q <= '0;
      wb_data_q <= '0;
      clr_q <= '0;
      scan_q <= '0;
      rv_q <= 1'b0;
      rrow_q <= '0;
      cnt_q <= '0;
      rp_q <= 1'b0;
      wp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_clr_q <= tgt_clr_d;
      s1_valid_q <= hit_acc;
      s1_row_q <= hit_row;
      s1_col_q <= hitAddress[COLBITS-1:0];
      wb_valid_q <= s1_valid_q;
      wb_row_q <= s1_row_q;
      wb_data_q <= new_data;
      clr_q <= in_clr ? clr_q + (ROWBITS-1)'(1) : '0;
      scan_q <= in_rd ? scan_q + (ROWBITS+1)'(issue) : '0;
      rv_q <= issue;
      rrow_q <= scan_q[ROWBITS-1:0];
      if (!in_rd || clearStart) begin
        cnt_q <= '0;
        rp_q <= 1'b0;
        wp_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 2'(push) - 2'(pop);
        rp_q <= rp_q ^ pop;
        wp_q <= wp_q ^ push;
      end
    end
  end
endmodule

// File: tb/tb_hit_bitmap_store.sv
// tb_hit_bitmap_store: directed vector table plus hand sequences for reset, saturation, stall, abort and clear/read collision
module tb_hit_bitmap_store;
  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic hitValid = 1'b0;
  logic [6:0] hitAddress = '0;
  logic hitReady, clearStart = 1'b0, readStart = 1'b0, outValid, outReady = 1'b0, readDone, busy;
  logic [3:0] outRow, outCount;
  logic [7:0] outBitmap;
  int checks = 0, errors = 0;
  int nb, dones, unstable, cyc, acc_cyc, done_cyc;
  int br[16], bb[16], bc[16];
  typedef struct packed {
    int nh;
    logic [3:0][6:0] h;
    int nb;
    logic [2:0][3:0] r;
    logic [2:0][7:0] bm;
    logic [2:0][3:0] ct;
  } vec_t;
  vec_t vecs[5];
  hit_bitmap_store dut (
    .clock(clock), .resetN(resetN), .hitValid(hitValid), .hitAddress(hitAddress), .hitReady(hitReady),
    .clearStart(clearStart), .readStart(readStart), .outValid(outValid), .outReady(outReady),
    .outRow(outRow), .outBitmap(outBitmap), .outCount(outCount), .readDone(readDone), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic send_hits(input int n, input logic [3:0][6:0] h);
    for (int i = 0; i < n; i++) begin
      hitValid = 1'b1;
      hitAddress = h[i];
      tick();
    end
    hitValid = 1'b0;
  endtask
  task automatic collect(input int stall);
    int wcnt;
    logic [15:0] snap;
    wcnt = 0;
    snap = '0;
    nb = 0;
    dones = 0;
    unstable = 0;
    acc_cyc = -1;
    done_cyc = -1;
    for (cyc = 0; cyc < 600; cyc++) begin
      tick();
      clearStart = 1'b0;
      readStart = 1'b0;
      if (readDone) begin
        dones++;
        done_cyc = cyc;
      end
      if (hitReady) break;
      if (outValid) begin
        if (wcnt == 0) snap = {outRow, outBitmap, outCount};
        else if ({outRow, outBitmap, outCount} != snap) unstable++;
        if (wcnt >= stall) begin
          outReady = 1'b1;
          if (nb < 16) begin
            br[nb] = int'(outRow);
            bb[nb] = int'(outBitmap);
            bc[nb] = int'(outCount);
          end
          nb++;
          acc_cyc = cyc;
          wcnt = 0;
        end else begin
          outReady = 1'b0;
          wcnt++;
        end
      end else begin
        outReady = 1'b0;
        wcnt = 0;
      end
    end
    outReady = 1'b0;
    if (cyc >= 600) chk("timeout_idle", cyc, 0);
  endtask
  task automatic do_clear();
    clearStart = 1'b1;
    collect(0);
  endtask
  task automatic rd_check(input string nm, input int stall, input int enb, input logic [2:0][3:0] er,
                          input logic [2:0][7:0] ebm, input logic [2:0][3:0] ect);
    readStart = 1'b1;
    collect(stall);
    chk({nm, "_beats"}, nb, enb);
    chk({nm, "_dones"}, dones, 1);
    for (int i = 0; i < enb && i < nb; i++) begin
      chk($sformatf("%s_row%0d", nm, i), br[i], int'(er[i]));
      chk($sformatf("%s_bitmap%0d", nm, i), bb[i], int'(ebm[i]));
      chk($sformatf("%s_count%0d", nm, i), bc[i], int'(ect[i]));
    end
  endtask
  initial begin
    int n, rdn;
    vecs[0] = '{nh: 0, h: '0, nb: 0, r: '0, bm: '0, ct: '0};
    vecs[1] = '{nh: 3, h: {7'h00, 7'h13, 7'h15, 7'h13}, nb: 1, r: {4'd0, 4'd0, 4'd2}, bm: {8'h0, 8'h0, 8'h28}, ct: {4'd0, 4'd0, 4'd3}};
    vecs[2] = '{nh: 3, h: {7'h00, 7'h79, 7'h2F, 7'h00}, nb: 3, r: {4'd15, 4'd5, 4'd0}, bm: {8'h02, 8'h80, 8'h01}, ct: {4'd1, 4'd1, 4'd1}};
    vecs[3] = '{nh: 4, h: {7'h08, 7'h10, 7'h09, 7'h08}, nb: 2, r: {4'd0, 4'd2, 4'd1}, bm: {8'h0, 8'h01, 8'h03}, ct: {4'd0, 4'd1, 4'd3}};
    vecs[4] = '{nh: 2, h: {7'h00, 7'h00, 7'h7F, 7'h7F}, nb: 1, r: {4'd0, 4'd0, 4'd15}, bm: {8'h0, 8'h0, 8'h80}, ct: {4'd0, 4'd0, 4'd2}};
    tick();
    tick();
    chk("rst_hitReady", int'(hitReady), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_outValid", int'(outValid), 0);
    chk("rst_readDone", int'(readDone), 0);
    resetN = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    chk("rst_busy_cycles", n, 8);
    chk("rst_then_hitReady", int'(hitReady), 1);
    for (int v = 0; v < 5; v++) begin
      do_clear();
      send_hits(vecs[v].nh, vecs[v].h);
      rd_check($sformatf("vec%0d", v), 0, vecs[v].nb, vecs[v].r, vecs[v].bm, vecs[v].ct);
    end
    do_clear();
    for (int i = 0; i < 20; i++) send_hits(1, {4{7'h08}});
    rd_check("sat20", 0, 1, {4'd0, 4'd0, 4'd1}, {8'h0, 8'h0, 8'h01}, {4'd0, 4'd0, 4'd15});
    do_clear();
    send_hits(3, {7'h00, 7'h79, 7'h2F, 7'h00});
    rd_check("stall", 10, 3, {4'd15, 4'd5, 4'd0}, {8'h02, 8'h80, 8'h01}, {4'd1, 4'd1, 4'd1});
    chk("stall_stable", unstable, 0);
    chk("stall_done_timing", done_cyc, acc_cyc + 1);
    rd_check("reread", 0, 3, {4'd15, 4'd5, 4'd0}, {8'h02, 8'h80, 8'h01}, {4'd1, 4'd1, 4'd1});
    readStart = 1'b1;
    outReady = 1'b1;
    tick();
    readStart = 1'b0;
    n = 0;
    while (!outValid && n < 100) begin
      n++;
      tick();
    end
    chk("abort_first_beat_row", int'(outRow), 0);
    tick();
    outReady = 1'b0;
    clearStart = 1'b1;
    tick();
    clearStart = 1'b0;
    chk("abort_outValid", int'(outValid), 0);
    rdn = int'(readDone);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
      rdn += int'(readDone);
    end
    chk("abort_busy_cycles", n, 8);
    chk("abort_no_readDone", rdn, 0);
    rd_check("abort_empty", 0, 0, '0, '0, '0);
    send_hits(1, {4{7'h13}});
    clearStart = 1'b1;
    readStart = 1'b1;
    collect(0);
    chk("both_beats", nb, 0);
    chk("both_dones", dones, 0);
    rd_check("both_empty", 0, 0, '0, '0, '0);
    send_hits(2, {7'h0, 7'h0, 7'h13, 7'h13});
    readStart = 1'b1;
    tick();
    readStart = 1'b0;
    tick();
    resetN = 1'b0;
    #1;
    chk("midrst_hitReady", int'(hitReady), 0);
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_outValid", int'(outValid), 0);
    tick();
    resetN = 1'b1;
    collect(0);
    rd_check("midrst_empty", 0, 0, '0, '0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
